// File: rtl/arith_unit_if.sv
// Operation request/result bundle for arith_unit.
// Optional dz signal is present only when ARITH_DZ_EN is defined.
interface arith_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] respuesta;
  logic [WIDTH-1:0] out_high;
  logic [WIDTH-1:0] out_low;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] residue;
  logic             busy;
  logic             done;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
`ifdef ARITH_DZ_EN
  logic             dz;
`endif

  modport master (
    output start, op, sign, a, b,
`ifdef ARITH_DZ_EN
    input  dz,
`endif
    input  respuesta, out_high, out_low, quotient, residue,
    input  busy, done, z, n, c, v
  );

  modport slave (
    input  start, op, sign, a, b,
`ifdef ARITH_DZ_EN
    output dz,
`endif
    output respuesta, out_high, out_low, quotient, residue,
    output busy, done, z, n, c, v
  );
endinterface

// File: rtl/arith_unit.sv
// Sequential add / shift-add multiply / restoring divide with Z/N/C/V flags.
// Optional ARITH_DZ_EN adds a divide-by-zero flag (dz) and keeps v clear on that case.
module arith_unit #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  arith_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               sign_r, neg_r, rneg_r, ovf_r;
  logic [WIDTH-1:0]   opd_r;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_r;   // product high half or partial remainder
  logic [WIDTH-1:0]   shf_r;   // multiplier or dividend/quotient shift register
  logic [WIDTH-1:0]   res_r, hi_r, lo_r, quo_r, rem_r;
  logic               busy_r, done_r, z_r, n_r, c_r, v_r;

  logic [WIDTH:0]     add_s, mul_sum_s, div_sh_s, div_diff_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, div_rem_nx_s, div_quo_nx_s, q_fix_s, r_fix_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               div_ge_s, mul_v_s, last_s, divz_s, div_ovf_s;

  // Single-step datapath shared by add, multiply and divide.
  always_comb begin
    add_s        = {1'b0, bus.a} + {1'b0, bus.b};
    abs_a_s      = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b_s      = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    divz_s       = (bus.b == {WIDTH{1'b0}});
    div_ovf_s    = bus.sign && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == {WIDTH{1'b1}});
    last_s       = (cnt_r == CW'(WIDTH-1));
    mul_sum_s    = {1'b0, acc_r} + (shf_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    prod_s       = {mul_sum_s, shf_r[WIDTH-1:1]};
    prod_fix_s   = neg_r ? -prod_s : prod_s;
    mul_v_s      = sign_r ? (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix_s[WIDTH-1]}})
                          : (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    div_sh_s     = {acc_r, shf_r[WIDTH-1]};
    div_ge_s     = (div_sh_s >= {1'b0, opd_r});
    div_diff_s   = div_ge_s ? (div_sh_s - {1'b0, opd_r}) : div_sh_s;
    div_rem_nx_s = div_diff_s[WIDTH-1:0];
    div_quo_nx_s = {shf_r[WIDTH-2:0], div_ge_s};
    q_fix_s      = neg_r ? -div_quo_nx_s : div_quo_nx_s;
    r_fix_s      = rneg_r ? -div_rem_nx_s : div_rem_nx_s;
  end

  // Operation FSM with registered results and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      sign_r  <= 1'b0;
      neg_r   <= 1'b0;
      rneg_r  <= 1'b0;
      ovf_r   <= 1'b0;
      opd_r   <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      shf_r   <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      z_r     <= 1'b0;
      n_r     <= 1'b0;
      c_r     <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sign_r <= bus.sign;
            cnt_r  <= {CW{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            case (bus.op)
              2'b00: begin
                res_r  <= add_s[WIDTH-1:0];
                c_r    <= add_s[WIDTH];
                v_r    <= (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
                z_r    <= (add_s[WIDTH-1:0] == {WIDTH{1'b0}});
                n_r    <= add_s[WIDTH-1];
                done_r <= 1'b1;
              end
              2'b01: begin
                opd_r   <= abs_a_s;
                shf_r   <= abs_b_s;
                neg_r   <= bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                busy_r  <= 1'b1;
                state_r <= MUL;
              end
              2'b10: begin
                if (divz_s) begin
                  res_r  <= {WIDTH{1'b1}};
                  quo_r  <= {WIDTH{1'b1}};
                  rem_r  <= bus.a;
                  z_r    <= 1'b0;
                  n_r    <= bus.sign;
                  c_r    <= 1'b0;
`ifdef ARITH_DZ_EN
                  v_r    <= 1'b0;
`else
                  v_r    <= 1'b1;
`endif
                  done_r <= 1'b1;
                end else begin
                  opd_r   <= abs_b_s;
                  shf_r   <= abs_a_s;
                  neg_r   <= bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  rneg_r  <= bus.sign && bus.a[WIDTH-1];
                  ovf_r   <= div_ovf_s;
                  busy_r  <= 1'b1;
                  state_r <= DIV;
                end
              end
              default: done_r <= 1'b1;
            endcase
          end
        end
        MUL: begin
          acc_r <= mul_sum_s[WIDTH:1];
          shf_r <= {mul_sum_s[0], shf_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            hi_r    <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r    <= prod_fix_s[WIDTH-1:0];
            res_r   <= prod_fix_s[WIDTH-1:0];
            z_r     <= (prod_fix_s == {(2*WIDTH){1'b0}});
            n_r     <= sign_r && prod_fix_s[2*WIDTH-1];
            c_r     <= 1'b0;
            v_r     <= mul_v_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        DIV: begin
          acc_r <= div_rem_nx_s;
          shf_r <= div_quo_nx_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            quo_r   <= q_fix_s;
            rem_r   <= r_fix_s;
            res_r   <= q_fix_s;
            z_r     <= (q_fix_s == {WIDTH{1'b0}});
            n_r     <= sign_r && q_fix_s[WIDTH-1];
            c_r     <= 1'b0;
            v_r     <= ovf_r;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef ARITH_DZ_EN
  logic dz_r;
  logic fin_s;

  // A completion happens on any accepted start in IDLE or on the last iteration.
  always_comb begin
    fin_s = ((state_r == IDLE) && bus.start) || ((state_r != IDLE) && last_s);
  end

  // dz is re-evaluated on every completion; only divide by zero sets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_r <= 1'b0;
    end else if (fin_s) begin
      dz_r <= (state_r == IDLE) && (bus.op == 2'b10) && divz_s;
    end
  end

  assign bus.dz = dz_r;
`endif

  assign bus.respuesta = res_r;
  assign bus.out_high  = hi_r;
  assign bus.out_low   = lo_r;
  assign bus.quotient  = quo_r;
  assign bus.residue   = rem_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.z         = z_r;
  assign bus.n         = n_r;
  assign bus.c         = c_r;
  assign bus.v         = v_r;
endmodule

// File: tb/tb_arith_unit.sv
// Directed scoreboard bench for arith_unit: expected results are queued at issue and checked at done.
module tb_arith_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  arith_unit_if #(.WIDTH(32)) ifc ();
  arith_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res, hi, lo, q, r;
    logic        z, n, c, v, dz, iter;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: full-width SV arithmetic, previous values kept for untouched fields.
  function automatic exp_t model(input exp_t p, input logic [1:0] op, input logic sg,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    logic [63:0] pr;
    longint pa, pb;
    int sa, sb;
    e = p;
    e.dz = 1'b0;
    e.lat = 1;
    e.iter = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
        e.z = (s[31:0] == 32'd0);
        e.n = s[31];
      end
      2'b01: begin
        e.lat = 33;
        e.iter = 1'b1;
        if (sg) begin
          pa = $signed(a);
          pb = $signed(b);
          pr = pa * pb;
        end else begin
          pr = {32'd0, a} * {32'd0, b};
        end
        e.hi = pr[63:32];
        e.lo = pr[31:0];
        e.res = pr[31:0];
        e.z = (pr == 64'd0);
        e.n = sg & pr[63];
        e.c = 1'b0;
        e.v = sg ? (pr[63:32] != {32{pr[31]}}) : (pr[63:32] != 32'd0);
      end
      2'b10: begin
        e.c = 1'b0;
        if (b == 32'd0) begin
          e.q = 32'hFFFF_FFFF;
          e.r = a;
`ifdef ARITH_DZ_EN
          e.v = 1'b0;
          e.dz = 1'b1;
`else
          e.v = 1'b1;
`endif
        end else begin
          e.lat = 33;
          e.iter = 1'b1;
          e.v = 1'b0;
          if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
            e.v = 1'b1;
          end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            e.q = sa / sb;
            e.r = sa % sb;
          end else begin
            e.q = a / b;
            e.r = a % b;
          end
        end
        e.res = e.q;
        e.z = (e.q == 32'd0);
        e.n = sg & e.q[31];
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input bit mid);
    exp_t e, g;
    int lat;
    bit got;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op = op;
    ifc.sign = sg;
    ifc.a = a;
    ifc.b = b;
    e = model(cur, op, sg, a, b);
    cur = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.a = $urandom;
    ifc.b = $urandom;
    ifc.sign = ~sg;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_run", ifc.busy, e.iter);
      if (mid && lat == 4) begin
        ifc.start = 1'b1;
        ifc.op = 2'b00;
      end
      if (mid && lat == 5) ifc.start = 1'b0;
      if (ifc.done) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (got) begin
      g = sbq.pop_front();
      check("latency", lat, g.lat);
      check("respuesta", ifc.respuesta, g.res);
      check("out_high", ifc.out_high, g.hi);
      check("out_low", ifc.out_low, g.lo);
      check("quotient", ifc.quotient, g.q);
      check("residue", ifc.residue, g.r);
      check("flags_zncv", {ifc.z, ifc.n, ifc.c, ifc.v}, {g.z, g.n, g.c, g.v});
`ifdef ARITH_DZ_EN
      check("dz", ifc.dz, g.dz);
`endif
      @(negedge clk);
      check("done_pulse", ifc.done, 0);
      check("busy_after", ifc.busy, 0);
    end
  endtask

  initial begin
    bit seen;
    ifc.start = 1'b0;
    ifc.op = 2'b00;
    ifc.sign = 1'b0;
    ifc.a = 32'd0;
    ifc.b = 32'd0;
    cur = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {ifc.respuesta, ifc.out_high}, 64'd0);
    check("rst_div", {ifc.quotient, ifc.residue}, 64'd0);
    check("rst_ctl", {ifc.out_low, ifc.busy, ifc.done, ifc.z, ifc.n, ifc.c, ifc.v}, 38'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'b00, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(2'b01, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    run_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 1'b0, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 1'b0, 32'd5, 32'd0, 1'b0);
    run_op(2'b11, 1'b1, 32'h1234_5678, 32'd9, 1'b0);
    run_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 1'b0);
    run_op(2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(2'($urandom_range(1, 2)), 1'($urandom), $urandom, $urandom, 1'b0);
    end
    run_op(2'b00, 1'b0, 32'd0, 32'd0, 1'b0);

    // Abort a divide with reset and confirm it never completes.
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op = 2'b10;
    ifc.sign = 1'b0;
    ifc.a = 32'd1000;
    ifc.b = 32'd3;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_rst", ifc.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_res", {ifc.respuesta, ifc.out_high, ifc.out_low}, 96'd0);
    check("rst_mid_div", {ifc.quotient, ifc.residue}, 64'd0);
    check("rst_mid_ctl", {ifc.busy, ifc.done, ifc.z, ifc.n, ifc.c, ifc.v}, 6'd0);
`ifdef ARITH_DZ_EN
    check("rst_mid_dz", ifc.dz, 0);
`endif
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.done) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 0);
    cur = '{default: 0};

    run_op(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
